drink_sequencer: RTL and testbench

- Order controller for the drink machine. It accepts a 4-bit drink code from the selection panel and collects coin credit.
- It sequences the drink-table lookup block (enable/code out, done in) and checks credit against price.
- It then times the pump, heater, ice and sugar actuators, and finally returns change.
- It sits between the front panel/coin acceptor and the drink-table lookup plus actuator drivers.

---
 rtl/drink_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_drink_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drink_sequencer.sv
// Drink machine order controller: coin credit, table lookup, price check, actuator timing, change.
// Optional DRINK_STATS_EN adds a served_count output counting completed dispenses.
module drink_sequencer #(
  parameter int BASE_TIME      = 8,
  parameter int EXTRA_TIME     = 4,
  parameter int LOOKUP_TIMEOUT = 20,
  parameter int COLD_PRICE     = 2,
  parameter int HOT_PRICE      = 3,
  parameter int EXTRA_PRICE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_code,
  output logic        req_ready,
  input  logic        coin_valid,
  input  logic [3:0]  coin_value,
  input  logic        cancel,
  output logic        lookup_en,
  output logic [3:0]  lookup_code,
  input  logic        lookup_done,
  output logic        pump_on,
  output logic        heater_on,
  output logic        ice_on,
  output logic        sugar_on,
  output logic [7:0]  credit,
  output logic        change_valid,
  output logic [7:0]  change_value,
  output logic        busy,
  output logic [1:0]  error_code,
`ifdef DRINK_STATS_EN
  output logic [15:0] served_count,
`endif
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    EXTRA    = 3'd4,
    CHANGE   = 3'd5
  } state_t;

  localparam int MAXT_A = (BASE_TIME > EXTRA_TIME) ? BASE_TIME : EXTRA_TIME;
  localparam int MAXT   = (MAXT_A > LOOKUP_TIMEOUT) ? MAXT_A : LOOKUP_TIMEOUT;
  localparam int CW     = (MAXT > 1) ? $clog2(MAXT + 1) : 1;

  state_t        state, state_n;
  logic [3:0]    code, code_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    credit_n;
  logic [1:0]    err_n;
  logic [8:0]    coin_sum;
  logic [7:0]    coin_credit;
  logic [7:0]    price;

  assign state_dbg = state;

  // Handshake: a request transfers on a cycle where req_valid & req_ready are both high,
  // except that a cancel with nonzero credit in that cycle takes precedence and the
  // request is not taken (requester keeps req_valid asserted to retry).
  always_comb begin
    state_n     = state;
    code_n      = code;
    cnt_n       = cnt;
    credit_n    = credit;
    err_n       = error_code;
    coin_sum    = {1'b0, credit} + {5'b0, coin_value};
    coin_credit = coin_sum[8] ? 8'hFF : coin_sum[7:0];
    price       = (code[2] ? 8'(HOT_PRICE) : 8'(COLD_PRICE)) +
                  (code[3] ? 8'(EXTRA_PRICE) : 8'd0);
    case (state)
      IDLE: begin
        if (coin_valid) credit_n = coin_credit;
        if (cancel && credit != 8'd0) begin
          state_n = CHANGE;
        end else if (req_valid) begin
          code_n  = req_code;
          err_n   = 2'b00;
          cnt_n   = '0;
          state_n = LOOKUP;
        end
      end
      LOOKUP: begin
        if (coin_valid) credit_n = coin_credit;
        // done beats both cancel and the final timeout cycle
        if (lookup_done) begin
          state_n = CHECK;
        end else if (cancel) begin
          state_n = IDLE;
        end else if (cnt == CW'(LOOKUP_TIMEOUT - 1)) begin
          err_n   = 2'b10;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHECK: begin
        if (credit >= price) begin
          credit_n = credit - price;
          cnt_n    = '0;
          state_n  = DISPENSE;
        end else begin
          err_n   = 2'b01;
          state_n = IDLE;
        end
      end
      DISPENSE: begin
        if (cnt == CW'(BASE_TIME - 1)) begin
          cnt_n   = '0;
          state_n = code[3] ? EXTRA : CHANGE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      EXTRA: begin
        if (cnt == CW'(EXTRA_TIME - 1)) begin
          cnt_n   = '0;
          state_n = CHANGE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHANGE: begin
        credit_n = 8'd0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code         <= 4'h0;
      cnt          <= '0;
      credit       <= 8'd0;
      error_code   <= 2'b00;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      lookup_en    <= 1'b0;
      lookup_code  <= 4'h0;
      pump_on      <= 1'b0;
      heater_on    <= 1'b0;
      ice_on       <= 1'b0;
      sugar_on     <= 1'b0;
      change_valid <= 1'b0;
      change_value <= 8'd0;
    end else begin
      state        <= state_n;
      code         <= code_n;
      cnt          <= cnt_n;
      credit       <= credit_n;
      error_code   <= err_n;
      req_ready    <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
      lookup_en    <= (state_n == LOOKUP);
      lookup_code  <= (state_n == LOOKUP) ? code_n : 4'h0;
      pump_on      <= (state_n == DISPENSE);
      heater_on    <= (state_n == DISPENSE) && code_n[2];
      ice_on       <= (state_n == EXTRA) && !code_n[2];
      sugar_on     <= (state_n == EXTRA) && code_n[2];
      change_valid <= (state_n == CHANGE);
      change_value <= (state_n == CHANGE) ? credit_n : 8'd0;
    end
  end

`ifdef DRINK_STATS_EN
  // Only completed dispenses count; a cancel refund also enters CHANGE but from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_count <= 16'd0;
    end else if (state_n == CHANGE && (state == DISPENSE || state == EXTRA)) begin
      served_count <= served_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drink_sequencer.sv
// Directed bench for drink_sequencer: change values go through an expected queue,
// actuator on-cycles are counted by a negedge monitor.
module tb_drink_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_code;
  logic       req_ready;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       cancel;
  logic       lookup_en;
  logic [3:0] lookup_code;
  logic       lookup_done;
  logic       pump_on, heater_on, ice_on, sugar_on;
  logic [7:0] credit;
  logic       change_valid;
  logic [7:0] change_value;
  logic       busy;
  logic [1:0] error_code;
  logic [2:0] state_dbg;
`ifdef DRINK_STATS_EN
  logic [15:0] served_count;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  int pump_c = 0, heater_c = 0, ice_c = 0, sugar_c = 0, len_c = 0;
  int b_pump, b_heater, b_ice, b_sugar, b_len;
  logic [7:0] exp_q[$];

  drink_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .lookup_en(lookup_en), .lookup_code(lookup_code), .lookup_done(lookup_done),
    .pump_on(pump_on), .heater_on(heater_on), .ice_on(ice_on), .sugar_on(sugar_on),
    .credit(credit), .change_valid(change_valid), .change_value(change_value),
    .busy(busy), .error_code(error_code),
`ifdef DRINK_STATS_EN
    .served_count(served_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // monitor: actuator cycle counts and change scoreboard
  always @(negedge clk) begin
    if (pump_on === 1'b1)   pump_c++;
    if (heater_on === 1'b1) heater_c++;
    if (ice_on === 1'b1)    ice_c++;
    if (sugar_on === 1'b1)  sugar_c++;
    if (lookup_en === 1'b1) len_c++;
    if (change_valid === 1'b1) begin
      if (exp_q.size() == 0) check("change_spurious", 16'(change_valid), 16'd0);
      else                   check("change_value", 16'(change_value), 16'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic put_coin(input logic [3:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    step(1);
    coin_valid = 1'b0;
    coin_value = 4'h0;
  endtask

  task automatic request(input logic [3:0] c);
    req_valid = 1'b1;
    req_code  = c;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic pulse_done();
    lookup_done = 1'b1;
    step(1);
    lookup_done = 1'b0;
  endtask

  task automatic mark();
    b_pump = pump_c; b_heater = heater_c; b_ice = ice_c; b_sugar = sugar_c; b_len = len_c;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    check(tag, 16'(busy), 16'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_code = 4'h0; coin_valid = 1'b0;
    coin_value = 4'h0; cancel = 1'b0; lookup_done = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_credit", 16'(credit), 16'd0);
    check("rst_error", 16'(error_code), 16'd0);
    check("rst_pump", 16'(pump_on), 16'd0);
    check("rst_change_valid", 16'(change_valid), 16'd0);
    check("rst_lookup_code", 16'(lookup_code), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_req_ready", 16'(req_ready), 16'd1);

    // hot drink 0101, lookup done after 3 cycles
    put_coin(4'd2);
    put_coin(4'd2);
    check("t1_credit4", 16'(credit), 16'd4);
    mark();
    exp_q.push_back(8'd1);
    request(4'b0101);
    check("t1_lookup_en", 16'(lookup_en), 16'd1);
    check("t1_lookup_code", 16'(lookup_code), 16'd5);
    step(2);
    pulse_done();
    check("t1_check_credit", 16'(credit), 16'd4);
    step(1);
    check("t1_credit1", 16'(credit), 16'd1);
    wait_idle("t1_idle", 40);
    check("t1_pump", 16'(pump_c - b_pump), 16'd8);
    check("t1_heater", 16'(heater_c - b_heater), 16'd8);
    check("t1_ice", 16'(ice_c - b_ice), 16'd0);
    check("t1_sugar", 16'(sugar_c - b_sugar), 16'd0);
    check("t1_credit0", 16'(credit), 16'd0);

    // insufficient credit: 1011 costs 3, credit 2
    put_coin(4'd2);
    mark();
    request(4'b1011);
    pulse_done();
    wait_idle("t2_idle", 10);
    check("t2_error", 16'(error_code), 16'd1);
    check("t2_credit", 16'(credit), 16'd2);
    check("t2_pump", 16'(pump_c - b_pump), 16'd0);
    check("t2_ice", 16'(ice_c - b_ice), 16'd0);

    // lookup timeout
    mark();
    request(4'b0000);
    wait_idle("t3_idle", 40);
    check("t3_lookup_cycles", 16'(len_c - b_len), 16'd20);
    check("t3_error", 16'(error_code), 16'd2);
    check("t3_credit", 16'(credit), 16'd2);

    // cold extra 1000, coin counted in the acceptance cycle: credit 2+3=5, price 3
    mark();
    exp_q.push_back(8'd2);
    coin_valid = 1'b1; coin_value = 4'd3;
    request(4'b1000);
    coin_valid = 1'b0; coin_value = 4'h0;
    check("t4_credit5", 16'(credit), 16'd5);
    check("t4_error_cleared", 16'(error_code), 16'd0);
    pulse_done();
    wait_idle("t4_idle", 40);
    check("t4_pump", 16'(pump_c - b_pump), 16'd8);
    check("t4_heater", 16'(heater_c - b_heater), 16'd0);
    check("t4_ice", 16'(ice_c - b_ice), 16'd4);
    check("t4_sugar", 16'(sugar_c - b_sugar), 16'd0);
    check("t4_credit0", 16'(credit), 16'd0);

    // cancel refund in IDLE
    put_coin(4'd7);
    exp_q.push_back(8'd7);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("t5_change_strobe", 16'(change_valid), 16'd1);
    wait_idle("t5_idle", 5);
    check("t5_credit0", 16'(credit), 16'd0);

    // cancel and coins during DISPENSE are ignored
    put_coin(4'd2);
    mark();
    exp_q.push_back(8'd0);
    request(4'b0001);
    pulse_done();
    step(1);
    cancel = 1'b1; coin_valid = 1'b1; coin_value = 4'd5;
    step(3);
    cancel = 1'b0; coin_valid = 1'b0; coin_value = 4'h0;
    check("t5_still_busy", 16'(busy), 16'd1);
    wait_idle("t5b_idle", 20);
    check("t5_pump", 16'(pump_c - b_pump), 16'd8);
    check("t5_credit_after", 16'(credit), 16'd0);
`ifdef DRINK_STATS_EN
    check("stats_served", served_count, 16'd3);
`endif

    // saturation, then reset mid-DISPENSE
    repeat (20) put_coin(4'd10);
    repeat (10) put_coin(4'd10);
    check("t6_saturate", 16'(credit), 16'd255);
    request(4'b0100);
    pulse_done();
    step(3);
    check("t6_pump_running", 16'(pump_on), 16'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_pump", 16'(pump_on), 16'd0);
    check("t6_rst_credit", 16'(credit), 16'd0);
    check("t6_rst_busy", 16'(busy), 16'd0);
`ifdef DRINK_STATS_EN
    check("stats_rst", served_count, 16'd0);
`endif
    step(1);
    rst = 1'b0;
    step(1);

    // done on the last timeout cycle wins -> CHECK fails on zero credit
    mark();
    request(4'b0000);
    step(19);
    pulse_done();
    check("t7_in_check", 16'(lookup_en), 16'd0);
    wait_idle("t7_idle", 10);
    check("t7_lookup_cycles", 16'(len_c - b_len), 16'd20);
    check("t7_error", 16'(error_code), 16'd1);

    step(2);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
